bus_arbit_rr: RTL and testbench
===============================

Name: bus_arbit_rr

Overview:
- N-master bus arbiter; successor to the two-master fixed-park arbiter.
- Sits between the bus masters' request lines and the shared-bus mux select.
- Always outputs exactly one one-hot grant.
- Round-robin fairness, grant hold while the owner keeps requesting, park on master 0 when idle, and an optional burst-limit forced handover.

Parameters:
- N_MASTERS, 4, number of masters; legal range 2..16.
- ID_W, $clog2(N_MASTERS), width of grant_id; derived, not overridden.
- MAX_HOLD, 16, maximum consecutive grant cycles under contention; used only with BUS_ARBIT_BURST_LIMIT_EN; legal range >=1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising clk.
- request  input  N_MASTERS  bit i = master i requests the bus.
- grant  output  N_MASTERS  one-hot grant; bit i = master i owns the bus.
- grant_id  output  ID_W  binary index of the set grant bit.
- parked  output  1  1 = grant is held by master 0 only because no request is pending.

Behaviour:
- Reset (reset=1 at a rising edge):
  - grant=1 (master 0), grant_id=0, parked=1.
  - Internal last_served=N_MASTERS-1, so master 0 is first in rotation.
  - hold_cnt=0.
  - Reset overrides every other event and aborts any ownership.
- Outputs are registered:
  - A decision uses request sampled at edge k and becomes visible after edge k.
  - Request-to-grant latency is 1 cycle.
  - No combinational path from request to grant.
- Invariant: grant is always exactly one-hot; grant_id always encodes it.
- Next-owner search: first i with request[i]=1, scanning circularly from last_served+1 and wrapping at N_MASTERS-1 -> 0.
- Owned state (parked=0, owner h = grant_id):
  - request[h]=1 -> keep h, subject to the burst limit.
  - request[h]=0 and any other request -> new owner by the circular search; last_served <= new owner; hold_cnt <= 0.
  - request == 0 -> park: grant=1 (master 0), parked=1; last_served stays h.
- Parked state:
  - request == 0 -> remain parked.
  - Any request -> owner by the circular search from last_served+1, including master 0; parked <= 0; last_served <= owner.
  - Master 0 gets no priority from parking.
- Simultaneous requests are resolved only by the circular order; no fixed priority.
- Owner drop and a new request in the same cycle -> handover directly, without passing through park.
- Single-requester case: that master wins within 1 cycle regardless of last_served.
- Request widths are fixed at N_MASTERS; no X-propagation requirements beyond reset.

Optional Feature:
- Macro: BUS_ARBIT_BURST_LIMIT_EN.
- With the macro defined:
  - hold_cnt (width $clog2(MAX_HOLD+1)) counts consecutive owned cycles of the current owner; it clears on owner change or park.
  - At the edge ending the owner's MAX_HOLD-th consecutive cycle, if request[h]=1 and any other request bit is set -> forced handover to the circular-search winner excluding h.
  - If no other requester is pending, h keeps the bus and hold_cnt saturates at MAX_HOLD.
  - A requester that appears later triggers the handover at the next edge.
- Without the macro: no counter logic is synthesised; the owner holds indefinitely while requesting; the MAX_HOLD parameter is ignored.

Test Plan (N_MASTERS=4, MAX_HOLD=4):
- reset=1 for 2 cycles with request=1111 -> grant=0001, grant_id=0, parked=1 throughout reset; first edge after release -> grant=0001, parked=0 (master 0 is next after last_served=3).
- From reset, request=0110 -> after 1 edge grant=0010, grant_id=1; hold request[1] for 5 cycles -> grant stays 0010; then request=0100 -> next edge grant=0100, grant_id=2.
- request=1111 with each owner dropping its bit for 1 cycle after being granted -> grant sequence 0001, 0010, 0100, 1000, 0001 (wrap-around).
- Owner 3, request -> 0000 -> next edge grant=0001, parked=1; then request=1001 -> grant=0001, parked=0 (0 follows 3); then request=1000 alone after master 0 drops -> grant=1000.
- Burst (macro defined): request=0011 held constant from reset -> master 0 granted 4 cycles, then grant=0010 for 4 cycles, then 0001; without macro -> grant stays 0001 indefinitely.
- reset=1 asserted mid-ownership (grant=0100, hold_cnt=2) -> at the next edge grant=0001, parked=1, hold_cnt=0; after release with request=0100 -> grant=0100 one cycle later.

Source files
------------

// File: rtl/bus_arbit_rr.sv
// Round-robin N-master bus arbiter: registered one-hot grant, hold while requesting, park on master 0.
// Optional burst-limit forced handover is enabled by defining BUS_ARBIT_BURST_LIMIT_EN.
module bus_arbit_rr #(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = 16,
  localparam int ID_W     = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] request,
  output logic [N_MASTERS-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 parked
);

  if ((N_MASTERS < 2) || (N_MASTERS > 16) || (MAX_HOLD < 1)) begin : g_param_check
    $error("bus_arbit_rr: N_MASTERS must be 2..16 and MAX_HOLD >= 1");
  end

  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic                 parked_q, parked_d;
  logic [ID_W-1:0]      pick_all_s;

  // First requester found scanning circularly from last+1, wrapping at N_MASTERS-1 -> 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                              input logic [ID_W-1:0]      last);
    logic [ID_W-1:0] win;
    logic            found;
    int              j;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      j = int'(last) + 32'sd1 + k;
      if (j >= N_MASTERS) begin
        j = j - N_MASTERS;
      end else begin
        j = j;
      end
      if (!found && req[j[ID_W-1:0]]) begin
        win   = j[ID_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  assign pick_all_s = rr_pick(request, last_q);

`ifdef BUS_ARBIT_BURST_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ID_W-1:0]   pick_oth_s;
  logic              others_s;

  assign others_s   = |(request & ~grant_q);
  assign pick_oth_s = rr_pick(request & ~grant_q, last_q);
`endif

  // Next-state decision: park, hold, handover or forced handover.
  always_comb begin
    id_d     = id_q;
    last_d   = last_q;
    parked_d = parked_q;
`ifdef BUS_ARBIT_BURST_LIMIT_EN
    hold_d   = hold_q;
`endif
    if (parked_q) begin
      if (|request) begin
        id_d     = pick_all_s;
        last_d   = pick_all_s;
        parked_d = 1'b0;
`ifdef BUS_ARBIT_BURST_LIMIT_EN
        hold_d   = '0;
`endif
      end else begin
        id_d = '0;
      end
    end else if (request[id_q]) begin
`ifdef BUS_ARBIT_BURST_LIMIT_EN
      // hold_q counts completed owned cycles; the current cycle is the MAX_HOLD-th when it equals MAX_HOLD-1
      if ((hold_q >= HOLD_W'(MAX_HOLD - 1)) && others_s) begin
        id_d   = pick_oth_s;
        last_d = pick_oth_s;
        hold_d = '0;
      end else if (hold_q < HOLD_W'(MAX_HOLD)) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = hold_q;
      end
`else
      id_d = id_q;
`endif
    end else if (|request) begin
      id_d   = pick_all_s;
      last_d = pick_all_s;
`ifdef BUS_ARBIT_BURST_LIMIT_EN
      hold_d = '0;
`endif
    end else begin
      id_d     = '0;
      parked_d = 1'b1;
`ifdef BUS_ARBIT_BURST_LIMIT_EN
      hold_d   = '0;
`endif
    end
  end

  assign grant_d = N_MASTERS'(1'b1) << id_d;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= N_MASTERS'(1'b1);
      id_q     <= '0;
      last_q   <= ID_W'(N_MASTERS - 1);
      parked_q <= 1'b1;
`ifdef BUS_ARBIT_BURST_LIMIT_EN
      hold_q   <= '0;
`endif
    end else begin
      grant_q  <= grant_d;
      id_q     <= id_d;
      last_q   <= last_d;
      parked_q <= parked_d;
`ifdef BUS_ARBIT_BURST_LIMIT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign parked   = parked_q;

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Bench for bus_arbit_rr (N_MASTERS=4, MAX_HOLD=4): directed table, burst sequences, random vs. reference model.
module tb_bus_arbit_rr;

  localparam int N  = 4;
  localparam int MH = 4;
`ifdef BUS_ARBIT_BURST_LIMIT_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         parked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbit_rr #(.N_MASTERS(N), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (reset),
    .request  (request),
    .grant    (grant),
    .grant_id (grant_id),
    .parked   (parked)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] id;
    logic       pk;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  int m_owner, m_last, m_run;
  bit m_parked;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q);
    reset   = r;
    request = q;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] id, input logic pk);
    vec_t v;
    v.rst = r; v.req = q; v.g = g; v.id = id; v.pk = pk;
    vecs.push_back(v);
  endfunction

  function automatic int m_search(input logic [3:0] q, input int last, input int excl);
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (last + off) % N;
      if (q[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic void m_step(input logic r, input logic [3:0] q);
    int w;
    if (r) begin
      m_owner = 0; m_parked = 1; m_last = N - 1; m_run = 0;
    end else if (m_parked) begin
      if (q != 4'b0000) begin
        m_owner = m_search(q, m_last, -1); m_last = m_owner; m_parked = 0; m_run = 1;
      end
    end else if (q[m_owner]) begin
      w = m_search(q, m_last, m_owner);
      if (BURST && m_run >= MH && w >= 0) begin
        m_owner = w; m_last = w; m_run = 1;
      end else if (m_run < MH) begin
        m_run++;
      end
    end else if (q != 4'b0000) begin
      m_owner = m_search(q, m_last, -1); m_last = m_owner; m_run = 1;
    end else begin
      m_owner = 0; m_parked = 1; m_run = 0;
    end
  endfunction

  initial begin
    logic [3:0] q;
    logic       r;
    int         exp_g;
    reset   = 1'b1;
    request = 4'b0000;

    // reset with all requesting, first grant after release
    add(1, 4'b1111, 4'b0001, 2'd0, 1);
    add(1, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    // grant hold and handover
    add(1, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b0110, 4'b0010, 2'd1, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b0010, 4'b0010, 2'd1, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    // rotation with wrap-around
    add(1, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    add(0, 4'b1110, 4'b0010, 2'd1, 0);
    add(0, 4'b1101, 4'b0100, 2'd2, 0);
    add(0, 4'b1011, 4'b1000, 2'd3, 0);
    add(0, 4'b0111, 4'b0001, 2'd0, 0);
    // park and unpark, master 0 gets no priority from parking
    add(0, 4'b1000, 4'b1000, 2'd3, 0);
    add(0, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b1001, 4'b0001, 2'd0, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 0);
    add(0, 4'b0001, 4'b0001, 2'd0, 0);
    add(0, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b1001, 4'b1000, 2'd3, 0);
    // reset mid-ownership, then direct handover without park
    add(1, 4'b0000, 4'b0001, 2'd0, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(1, 4'b0100, 4'b0001, 2'd0, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].g));
      check($sformatf("vec%0d_id", i), int'(grant_id), int'(vecs[i].id));
      check($sformatf("vec%0d_parked", i), int'(parked), int'(vecs[i].pk));
    end

    // constant contention from reset: burst limit rotates every MH cycles
    drive(1, 4'b0000);
    for (int k = 1; k <= 12; k++) begin
      drive(0, 4'b0011);
      exp_g = (BURST && k > MH && k <= 2 * MH) ? 2 : 1;
      check($sformatf("burst_k%0d", k), int'(grant), exp_g);
    end

    // late contender after the owner saturated its hold count
    drive(1, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 4'b0001);
      check($sformatf("solo_k%0d", k), int'(grant), 1);
    end
    drive(0, 4'b0011);
    check("late_contender", int'(grant), BURST ? 2 : 1);

    // randomized stimulus vs. reference model
    drive(1, 4'b0000);
    m_step(1'b1, 4'b0000);
    q = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) != 0) q = 4'($urandom_range(0, 15));
      m_step(r, q);
      drive(r, q);
      check("rnd_grant", int'(grant), 1 << m_owner);
      check("rnd_id", int'(grant_id), m_owner);
      check("rnd_parked", int'(parked), int'(m_parked));
      check("rnd_onehot", int'($onehot(grant)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
